// File: rtl/hazard_ctrl_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit_if
//
// Purpose: bundles every hazard-related signal between the 5-stage pipeline
// (F/D/E/M/W) and the hazard/forwarding controller.
//
// Handshake: the controller raises mdu_start for exactly one cycle to launch
// the MDU. The MDU answers with a one-cycle mdu_done pulse. mdu_done is only
// honoured while the controller reports mdu_busy; a pulse at any other time
// is ignored. There is no backpressure on either pulse.
//
// Modports:
//   master : pipeline side. Drives stage indices/controls, redirect_E and
//            mdu_done. Receives stalls, flushes, forwarding selects, MDU
//            control and the perf counters.
//   slave  : hazard controller side (the mirror of master).
//
// Signal summary (REG_AW = register index width):
//   rs1_D/rs2_D, use_rs1_D/use_rs2_D   D-stage sources and their read enables
//   rs1_E/rs2_E                        E-stage sources (forwarding compare)
//   rd_E, reg_write_E, mem_read_E,
//   mdu_en_E                           E-stage destination and controls
//   rd_M/rd_W, reg_write_M/W           M/W destinations and write enables
//   redirect_E                         taken branch/jump resolved in E
//   mdu_done                           MDU result valid pulse
//   stall_F/D/E, flush_D/E, bubble_M   per-stage hold / NOP insertion
//   fwd_a_sel/fwd_b_sel                00 regfile, 01 M alu_result, 10 W data
//   mdu_start, mdu_busy, mdu_err       MDU launch, busy, sticky timeout flag
//   perf_stall_cyc, perf_flush_cnt     optional perf counters (0 if disabled)
// -----------------------------------------------------------------------------
interface hazard_ctrl_unit_if #(
  parameter int REG_AW = 5
);
  // D stage
  logic [REG_AW-1:0] rs1_D;
  logic [REG_AW-1:0] rs2_D;
  logic              use_rs1_D;
  logic              use_rs2_D;
  // E stage
  logic [REG_AW-1:0] rs1_E;
  logic [REG_AW-1:0] rs2_E;
  logic [REG_AW-1:0] rd_E;
  logic              reg_write_E;
  logic              mem_read_E;
  logic              mdu_en_E;
  logic              redirect_E;
  // M / W stages
  logic [REG_AW-1:0] rd_M;
  logic [REG_AW-1:0] rd_W;
  logic              reg_write_M;
  logic              reg_write_W;
  // MDU handshake
  logic              mdu_done;
  logic              mdu_start;
  logic              mdu_busy;
  logic              mdu_err;
  // Pipeline control
  logic              stall_F;
  logic              stall_D;
  logic              stall_E;
  logic              flush_D;
  logic              flush_E;
  logic              bubble_M;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  // Performance counters
  logic [31:0]       perf_stall_cyc;
  logic [31:0]       perf_flush_cnt;

  modport master (
    output rs1_D, rs2_D, use_rs1_D, use_rs2_D,
    output rs1_E, rs2_E, rd_E, reg_write_E, mem_read_E, mdu_en_E, redirect_E,
    output rd_M, rd_W, reg_write_M, reg_write_W,
    output mdu_done,
    input  mdu_start, mdu_busy, mdu_err,
    input  stall_F, stall_D, stall_E, flush_D, flush_E, bubble_M,
    input  fwd_a_sel, fwd_b_sel,
    input  perf_stall_cyc, perf_flush_cnt
  );

  modport slave (
    input  rs1_D, rs2_D, use_rs1_D, use_rs2_D,
    input  rs1_E, rs2_E, rd_E, reg_write_E, mem_read_E, mdu_en_E, redirect_E,
    input  rd_M, rd_W, reg_write_M, reg_write_W,
    input  mdu_done,
    output mdu_start, mdu_busy, mdu_err,
    output stall_F, stall_D, stall_E, flush_D, flush_E, bubble_M,
    output fwd_a_sel, fwd_b_sel,
    output perf_stall_cyc, perf_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Purpose: centralised hazard/forwarding controller for the 5-stage RV32IMF
// pipeline. Produces per-stage stall/flush, E-stage operand forwarding
// selects, load-use bubbles, and an IDLE/BUSY/DONE FSM that holds E while the
// multi-cycle MDU (mul/div) works.
//
// Parameters:
//   REG_AW       register index width (must match the interface)
//   MDU_TIMEOUT  max BUSY cycles before a forced release; 1..2**CNT_W-1
//   CNT_W        width of the BUSY cycle counter
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; every output reads 0 while low
//   bus          hazard_ctrl_unit_if.slave (see interface header)
//   o_dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Optional feature: define HAZARD_PERF_EN to build the two 32-bit perf
// counters (cycles with any stall high, cycles with flush_D high). Without
// it the perf outputs are tied to 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
  parameter int REG_AW      = 5,
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_ctrl_unit_if.slave  bus,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(MDU_TIMEOUT);
  localparam logic [1:0]       L_FWD_RF  = 2'b00;
  localparam logic [1:0]       L_FWD_M   = 2'b01;
  localparam logic [1:0]       L_FWD_W   = 2'b10;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               r_err;
  logic               w_err_nxt;

  // Raw (ungated) control decisions
  logic               w_stall_F;
  logic               w_stall_D;
  logic               w_stall_E;
  logic               w_flush_D;
  logic               w_flush_E;
  logic               w_bubble_M;
  logic               w_mdu_start;
  logic               w_mdu_busy;
  logic [1:0]         w_fwd_a;
  logic [1:0]         w_fwd_b;
  logic               w_load_use;
  logic               w_timeout;

  // Local copies of the indices at the module's own width
  logic [REG_AW-1:0]  w_rs1_D;
  logic [REG_AW-1:0]  w_rs2_D;
  logic [REG_AW-1:0]  w_rs1_E;
  logic [REG_AW-1:0]  w_rs2_E;
  logic [REG_AW-1:0]  w_rd_E;
  logic [REG_AW-1:0]  w_rd_M;
  logic [REG_AW-1:0]  w_rd_W;

  assign w_rs1_D = bus.rs1_D;
  assign w_rs2_D = bus.rs2_D;
  assign w_rs1_E = bus.rs1_E;
  assign w_rs2_E = bus.rs2_E;
  assign w_rd_E  = bus.rd_E;
  assign w_rd_M  = bus.rd_M;
  assign w_rd_W  = bus.rd_W;

  // ---------------------------------------------------------------------------
  // Forwarding: the younger producer (M) wins over W; x0 never forwards.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_fwd_a = L_FWD_RF;
    if (bus.reg_write_M && (w_rd_M != '0) && (w_rd_M == w_rs1_E)) begin
      w_fwd_a = L_FWD_M;
    end else if (bus.reg_write_W && (w_rd_W != '0) && (w_rd_W == w_rs1_E)) begin
      w_fwd_a = L_FWD_W;
    end
  end

  always_comb begin
    w_fwd_b = L_FWD_RF;
    if (bus.reg_write_M && (w_rd_M != '0) && (w_rd_M == w_rs2_E)) begin
      w_fwd_b = L_FWD_M;
    end else if (bus.reg_write_W && (w_rd_W != '0) && (w_rd_W == w_rs2_E)) begin
      w_fwd_b = L_FWD_W;
    end
  end

  // ---------------------------------------------------------------------------
  // Load-use detect: a load in E whose result the D instruction needs cannot
  // be forwarded in time, so D waits one cycle behind a bubble in E.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_load_use = 1'b0;
    if (bus.mem_read_E && bus.reg_write_E && (w_rd_E != '0)) begin
      w_load_use = (bus.use_rs1_D && (w_rs1_D == w_rd_E)) ||
                   (bus.use_rs2_D && (w_rs2_D == w_rd_E));
    end
  end

  // The counter holds the number of BUSY cycles already completed, so the
  // incremented value equals MDU_TIMEOUT in the MDU_TIMEOUT-th BUSY cycle.
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (w_cnt_inc == L_TIMEOUT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_stall_F   = 1'b0;
    w_stall_D   = 1'b0;
    w_stall_E   = 1'b0;
    w_flush_D   = 1'b0;
    w_flush_E   = 1'b0;
    w_bubble_M  = 1'b0;
    w_mdu_start = 1'b0;
    w_mdu_busy  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // A redirect squashes the wrong-path D and E instructions; it must
        // not also stall, or the fetch of the target would be lost.
        if (bus.redirect_E) begin
          w_flush_D = 1'b1;
          w_flush_E = 1'b1;
        end else if (w_load_use) begin
          w_stall_F = 1'b1;
          w_stall_D = 1'b1;
          w_flush_E = 1'b1;
        end
        // An MDU op on the wrong path of a redirect is never launched.
        if (bus.mdu_en_E && !bus.redirect_E) begin
          w_mdu_start = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // Hold everything up to E; M receives NOPs so the held op in E is
        // not duplicated down the pipe.
        w_stall_F  = 1'b1;
        w_stall_D  = 1'b1;
        w_stall_E  = 1'b1;
        w_bubble_M = 1'b1;
        w_mdu_busy = 1'b1;
        w_cnt_nxt  = w_cnt_inc;
        if (bus.mdu_done) begin
          // A done arriving together with the timeout is a normal finish.
          w_state_nxt = ST_DONE;
        end else if (w_timeout) begin
          w_state_nxt = ST_DONE;
          w_err_nxt   = 1'b1;
        end
      end

      ST_DONE: begin
        // E advances with the result this cycle; the op still visible in E
        // is the finished one, so neither a restart nor hazard checks apply.
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Combinational outputs are gated so the whole block reads 0 while
  // reset is held, regardless of what the pipeline presents.
  // ---------------------------------------------------------------------------
  assign bus.stall_F   = rst_n & w_stall_F;
  assign bus.stall_D   = rst_n & w_stall_D;
  assign bus.stall_E   = rst_n & w_stall_E;
  assign bus.flush_D   = rst_n & w_flush_D;
  assign bus.flush_E   = rst_n & w_flush_E;
  assign bus.bubble_M  = rst_n & w_bubble_M;
  assign bus.mdu_start = rst_n & w_mdu_start;
  assign bus.mdu_busy  = rst_n & w_mdu_busy;
  assign bus.mdu_err   = r_err;
  assign bus.fwd_a_sel = rst_n ? w_fwd_a : L_FWD_RF;
  assign bus.fwd_b_sel = rst_n ? w_fwd_b : L_FWD_RF;
  assign o_dbg_state   = r_state;

  // ---------------------------------------------------------------------------
  // Optional performance counters (free-running, wrap at 2**32)
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;
  logic        w_any_stall;

  assign w_any_stall = w_stall_F | w_stall_D | w_stall_E;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_any_stall) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (w_flush_D) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign bus.perf_stall_cyc = r_perf_stall;
  assign bus.perf_flush_cnt = r_perf_flush;
`else
  assign bus.perf_stall_cyc = '0;
  assign bus.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_unit
//
// Directed bench for hazard_ctrl_unit with MDU_TIMEOUT = 8. Inputs are driven
// 1 time unit after the rising edge, outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

  localparam int REG_AW = 5;
  localparam int TMO    = 8;
  localparam int CNT_W  = 7;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_AW(REG_AW)) hif ();

  hazard_ctrl_unit #(
    .REG_AW      (REG_AW),
    .MDU_TIMEOUT (TMO),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (hif),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic clear_inputs();
    hif.rs1_D = '0; hif.rs2_D = '0; hif.use_rs1_D = 1'b0; hif.use_rs2_D = 1'b0;
    hif.rs1_E = '0; hif.rs2_E = '0; hif.rd_E = '0;
    hif.reg_write_E = 1'b0; hif.mem_read_E = 1'b0; hif.mdu_en_E = 1'b0;
    hif.redirect_E = 1'b0;
    hif.rd_M = '0; hif.rd_W = '0; hif.reg_write_M = 1'b0; hif.reg_write_W = 1'b0;
    hif.mdu_done = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // LW rd in E, D instruction reading rs2 = src
  task automatic drive_load_use(input logic [4:0] rd, input logic [4:0] src, input logic use2);
    hif.mem_read_E  = 1'b1;
    hif.reg_write_E = 1'b1;
    hif.rd_E        = rd;
    hif.use_rs2_D   = use2;
    hif.rs2_D       = src;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int n_cnt;

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    // Inputs that would produce nonzero outputs if reset were not held
    hif.reg_write_M = 1'b1; hif.rd_M = 5'd5; hif.rs1_E = 5'd5;
    hif.mdu_en_E = 1'b1; hif.redirect_E = 1'b1;
    settle();
    chk("rst_fwd_a",   hif.fwd_a_sel, 0);
    chk("rst_flush_d", hif.flush_D,   0);
    chk("rst_start",   hif.mdu_start, 0);
    chk("rst_busy",    hif.mdu_busy,  0);
    chk("rst_err",     hif.mdu_err,   0);
    chk("rst_state",   dbg_state,     0);
    repeat (2) @(posedge clk);
    #1;
    clear_inputs();
    rst_n = 1'b1;
    settle();

    // --- Forwarding ---------------------------------------------------------
    hif.reg_write_M = 1'b1; hif.rd_M = 5'd5; hif.rs1_E = 5'd5; hif.rs2_E = 5'd6;
    settle();
    chk("fwd_a_from_m", hif.fwd_a_sel, 2'b01);
    chk("fwd_b_none",   hif.fwd_b_sel, 2'b00);

    hif.reg_write_M = 1'b0; hif.reg_write_W = 1'b1; hif.rd_W = 5'd5;
    settle();
    chk("fwd_a_from_w", hif.fwd_a_sel, 2'b10);

    hif.reg_write_M = 1'b1; hif.rd_M = 5'd7; hif.rd_W = 5'd7; hif.rs2_E = 5'd7;
    settle();
    chk("fwd_b_m_beats_w", hif.fwd_b_sel, 2'b01);

    hif.rd_M = 5'd0; hif.rd_W = 5'd0; hif.rs1_E = 5'd0;
    settle();
    chk("fwd_a_x0", hif.fwd_a_sel, 2'b00);

    // --- Load-use -----------------------------------------------------------
    tick();
    clear_inputs();
    drive_load_use(5'd3, 5'd3, 1'b1);
    settle();
    chk("lu_stall_f", hif.stall_F, 1);
    chk("lu_stall_d", hif.stall_D, 1);
    chk("lu_flush_e", hif.flush_E, 1);
    chk("lu_stall_e", hif.stall_E, 0);
    chk("lu_flush_d", hif.flush_D, 0);
    tick();
    clear_inputs(); // bubble now in E
    settle();
    chk("lu_released", {hif.stall_F, hif.stall_D, hif.flush_E}, 3'b000);

    drive_load_use(5'd0, 5'd0, 1'b1);
    settle();
    chk("lu_x0_no_stall", hif.stall_F, 0);
    drive_load_use(5'd3, 5'd3, 1'b0);
    settle();
    chk("lu_unused_src", hif.stall_D, 0);

    // --- Redirect overrides load-use ----------------------------------------
    drive_load_use(5'd3, 5'd3, 1'b1);
    hif.redirect_E = 1'b1;
    settle();
    chk("redir_flush_d", hif.flush_D, 1);
    chk("redir_flush_e", hif.flush_E, 1);
    chk("redir_stall_f", hif.stall_F, 0);

    // --- Redirect suppresses MDU launch --------------------------------------
    tick();
    clear_inputs();
    hif.redirect_E = 1'b1; hif.mdu_en_E = 1'b1;
    settle();
    chk("redir_no_start", hif.mdu_start, 0);
    tick();
    clear_inputs();
    settle();
    chk("redir_stay_idle", dbg_state, 0);

    // --- MUL, done 5 cycles after start ------------------------------------
    hif.mdu_en_E = 1'b1;
    settle();
    chk("mul_start",       hif.mdu_start, 1);
    chk("mul_start_nostl", hif.stall_E,   0);
    n_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      hif.mdu_done = (i == 5);
      if (i == 3) drive_load_use(5'd3, 5'd3, 1'b1);
      else begin
        hif.mem_read_E = 1'b0; hif.reg_write_E = 1'b0; hif.use_rs2_D = 1'b0;
      end
      settle();
      if (hif.stall_E) n_cnt++;
      if (i == 1) begin
        chk("mul_start_pulse", hif.mdu_start, 0);
        chk("mul_busy",        hif.mdu_busy,  1);
        chk("mul_bubble_m",    hif.bubble_M,  1);
        chk("mul_stall_f",     hif.stall_F,   1);
      end
      if (i == 3) chk("busy_lu_suppressed", hif.flush_E, 0);
    end
    chk("mul_stall_cycles", n_cnt, 5);
    tick();
    hif.mdu_done = 1'b0;
    settle();
    chk("mul_done_state", dbg_state,     2);
    chk("mul_done_stall", hif.stall_E,   0);
    chk("mul_done_busy",  hif.mdu_busy,  0);
    chk("mul_no_restart", hif.mdu_start, 0);
    tick();
    hif.mdu_en_E = 1'b0; hif.mdu_done = 1'b1; // stray done in IDLE
    settle();
    chk("mul_back_idle", dbg_state, 0);
    tick();
    hif.mdu_done = 1'b0;
    settle();
    chk("stray_done_ignored", dbg_state, 0);
    chk("mul_no_err",         hif.mdu_err, 0);

    // --- Done coincident with timeout (8th BUSY cycle) ----------------------
    hif.mdu_en_E = 1'b1;
    settle();
    chk("coin_start", hif.mdu_start, 1);
    n_cnt = 0;
    for (int i = 1; i <= TMO; i++) begin
      tick();
      hif.mdu_done = (i == TMO);
      settle();
      if (hif.mdu_busy) n_cnt++;
    end
    chk("coin_busy_cycles", n_cnt, TMO);
    tick();
    hif.mdu_done = 1'b0;
    settle();
    chk("coin_done_state", dbg_state,   2);
    chk("coin_no_err",     hif.mdu_err, 0);
    tick();
    hif.mdu_en_E = 1'b0;
    settle();

    // --- Timeout ------------------------------------------------------------
    hif.mdu_en_E = 1'b1;
    settle();
    chk("tmo_start", hif.mdu_start, 1);
    n_cnt = 0;
    tick();
    while (hif.mdu_busy && n_cnt < 50) begin
      n_cnt++;
      tick();
    end
    chk("tmo_busy_cycles", n_cnt,       TMO);
    chk("tmo_done_state",  dbg_state,   2);
    chk("tmo_err_set",     hif.mdu_err, 1);
    tick();
    hif.mdu_en_E = 1'b0;
    settle();
    chk("tmo_idle", dbg_state, 0);
    repeat (3) tick();
    chk("tmo_err_sticky", hif.mdu_err, 1);

    // A clean op afterwards leaves the flag set
    hif.mdu_en_E = 1'b1;
    tick();
    hif.mdu_done = 1'b1;
    tick();
    hif.mdu_done = 1'b0;
    settle();
    chk("clean_op_done",    dbg_state,   2);
    chk("err_still_sticky", hif.mdu_err, 1);
    tick();
    hif.mdu_en_E = 1'b0;
    settle();

    // --- Reset mid-BUSY ------------------------------------------------------
    hif.mdu_en_E = 1'b1;
    tick();
    tick();
    chk("pre_rst_busy", hif.mdu_busy, 1);
    rst_n = 1'b0;
    settle();
    chk("rst_mid_busy",  hif.mdu_busy, 0);
    chk("rst_mid_state", dbg_state,    0);
    chk("rst_mid_stall", hif.stall_E,  0);
    chk("rst_clears_err", hif.mdu_err, 0);
    hif.mdu_en_E = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    chk("rst_no_replay", hif.mdu_start, 0);
    tick();
    chk("rst_stay_idle", dbg_state, 0);

`ifndef HAZARD_PERF_EN
    chk("perf_stall_tied", hif.perf_stall_cyc, 0);
    chk("perf_flush_tied", hif.perf_flush_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
